wb_trace_fifo: RTL and testbench

Write-back trace buffer that sits directly downstream of the core's WB stage. In every cycle the core asserts its write-back enable, the block captures the 16-bit write-back result together with an 8-bit cycle stamp. It queues these entries in a small FIFO and presents them on a valid/ready port to a host, debug UART or display driver. This lets the retirement stream be inspected without stalling the pipeline: the core never waits, and overflow is counted rather than back-pressured.

---
 rtl/rsaasip_pkg.sv | 15 +
 rtl/wb_trace_mem.sv | 36 +++
 rtl/wb_trace_fifo.sv | 122 ++++++++++++
 tb/tb_wb_trace_fifo.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/rsaasip_pkg.sv
// Shared definitions for the write-back trace buffer.
//   ARQ_DEFAULT      default width of the write-back result
//   STAMP_W_DEFAULT  default width of the cycle stamp
//   wb_trace_entry_t one queued entry: {stamp, data}
package rsaasip_pkg;

  localparam int ARQ_DEFAULT     = 16;
  localparam int STAMP_W_DEFAULT = 8;

  typedef struct packed {
    logic [STAMP_W_DEFAULT-1:0] stamp;
    logic [ARQ_DEFAULT-1:0]     data;
  } wb_trace_entry_t;

endpackage

// File: rtl/wb_trace_mem.sv
// DEPTH x entry register array for the trace FIFO.
//   clk      clock, writes on rising edge
//   rst      asynchronous active-low reset, clears every entry to 0
//   we       write enable
//   wr_addr  write address
//   wr_data  entry to store
//   rd_addr  read address
//   rd_data  entry at rd_addr (combinational read)
module wb_trace_mem
  import rsaasip_pkg::*;
#(
  parameter int  DEPTH   = 8,
  parameter type entry_t = wb_trace_entry_t
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  entry_t                   wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output entry_t                   rd_data
);

  entry_t mem_q [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/wb_trace_fifo.sv
// Write-back trace buffer: captures {stamp, wb_data} whenever wb_en is high and
// presents the entries on a show-ahead valid/ready port. The core is never
// stalled; captures that find the FIFO full (with no concurrent pop) are dropped
// and counted.
//   clk         clock
//   rst         asynchronous active-low reset
//   clr         synchronous flush of FIFO, overflow and drop_count (not stamp)
//   wb_en       capture request from the WB stage
//   wb_data     write-back result
//   out_ready   consumer accepts the head entry
//   out_valid   head entry present
//   out_data    head entry result
//   out_stamp   head entry cycle stamp
//   count       occupied entries
//   full/empty  occupancy flags
//   overflow    sticky, set on any dropped capture
//   drop_count  dropped captures, saturating at 255
module wb_trace_fifo
  import rsaasip_pkg::*;
#(
  parameter int ARQ     = ARQ_DEFAULT,
  parameter int DEPTH   = 8,
  parameter int STAMP_W = STAMP_W_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   wb_en,
  input  logic [ARQ-1:0]         wb_data,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [ARQ-1:0]         out_data,
  output logic [STAMP_W-1:0]     out_stamp,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty,
  output logic                   overflow,
  output logic [7:0]             drop_count
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [STAMP_W-1:0] stamp;
    logic [ARQ-1:0]     data;
  } entry_t;

  logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [AW:0]        count_q;
  logic [STAMP_W-1:0] stamp_q;
  logic               overflow_q;
  logic [7:0]         drop_q;
  logic               push, pop, drop, mem_we;
  entry_t             wr_entry, head;

  assign empty     = (count_q == '0);
  assign full      = (count_q == (AW+1)'(DEPTH));
  assign out_valid = !empty;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign drop_count = drop_q;

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push
  // alongside it. An empty FIFO has no pop, so there is no bypass path.
  assign pop    = out_valid && out_ready;
  assign push   = wb_en && (!full || pop);
  assign drop   = wb_en && full && !pop;
  assign mem_we = push && !clr;

  assign wr_entry = '{stamp: stamp_q, data: wb_data};

  wb_trace_mem #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .we      (mem_we),
    .wr_addr (wr_ptr_q),
    .wr_data (wr_entry),
    .rd_addr (rd_ptr_q),
    .rd_data (head)
  );

  assign out_data  = head.data;
  assign out_stamp = head.stamp;

  // Free-running stamp; deliberately untouched by clr.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stamp_q <= '0;
    else      stamp_q <= stamp_q + STAMP_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else if (clr) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
      if (drop) begin
        overflow_q <= 1'b1;
        if (drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_wb_trace_fifo.sv
module tb_wb_trace_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clr = 1'b0;
  logic        wb_en = 1'b0;
  logic [15:0] wb_data = '0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [15:0] out_data;
  logic [7:0]  out_stamp;
  logic [3:0]  count;
  logic        full, empty, overflow;
  logic [7:0]  drop_count;

  wb_trace_fifo dut (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .wb_en      (wb_en),
    .wb_data    (wb_data),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_stamp  (out_stamp),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [23:0] sb[$];
  logic        ov_m = 1'b0;
  logic [7:0]  drop_m = '0;
  logic [7:0]  stamp_m;

  always @(posedge clk or negedge rst) begin
    if (!rst) stamp_m <= '0;
    else      stamp_m <= stamp_m + 8'd1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state();
    chk("out_valid", {31'd0, out_valid}, {31'd0, sb.size() != 0});
    chk("count", {28'd0, count}, 32'(sb.size()));
    chk("empty", {31'd0, empty}, {31'd0, sb.size() == 0});
    chk("full", {31'd0, full}, {31'd0, sb.size() == 8});
    chk("overflow", {31'd0, overflow}, {31'd0, ov_m});
    chk("drop_count", {24'd0, drop_count}, {24'd0, drop_m});
    if (sb.size() != 0) begin
      chk("out_data", {16'd0, out_data}, {16'd0, sb[0][15:0]});
      chk("out_stamp", {24'd0, out_stamp}, {24'd0, sb[0][23:16]});
    end
  endtask

  // Called just after a falling edge: checks, drives, updates the scoreboard,
  // then advances to the next falling edge.
  task automatic step(input logic en, input logic [15:0] d, input logic rdy, input logic c);
    logic p_pop, p_push;
    check_state();
    wb_en = en; wb_data = d; out_ready = rdy; clr = c;
    p_pop  = rdy && (sb.size() != 0);
    p_push = en && ((sb.size() < 8) || p_pop);
    if (c) begin
      sb.delete();
      ov_m = 1'b0;
      drop_m = '0;
    end else begin
      if (p_pop) void'(sb.pop_front());
      if (p_push) sb.push_back({stamp_m, d});
      if (en && !p_push) begin
        ov_m = 1'b1;
        if (drop_m != 8'hFF) drop_m = drop_m + 8'd1;
      end
    end
    @(posedge clk);
    @(negedge clk);
    wb_en = 1'b0; out_ready = 1'b0; clr = 1'b0;
  endtask

  initial begin
    // reset state
    #2;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_count", {28'd0, count}, 32'd0);
    chk("rst_data", {16'd0, out_data}, 32'd0);
    chk("rst_stamp", {24'd0, out_stamp}, 32'd0);
    chk("rst_drop", {24'd0, drop_count}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // single capture at stamp 3
    for (int i = 0; i < 3; i++) step(0, 16'h0, 0, 0);
    step(1, 16'h00A5, 0, 0);
    chk("single_valid", {31'd0, out_valid}, 32'd1);
    chk("single_data", {16'd0, out_data}, 32'h00A5);
    chk("single_stamp", {24'd0, out_stamp}, 32'd3);
    chk("single_count", {28'd0, count}, 32'd1);
    step(0, 16'h0, 1, 0);
    chk("single_empty", {31'd0, empty}, 32'd1);

    // fill and overflow
    for (int i = 1; i <= 10; i++) step(1, 16'(i), 0, 0);
    chk("ovf_full", {31'd0, full}, 32'd1);
    chk("ovf_count", {28'd0, count}, 32'd8);
    chk("ovf_flag", {31'd0, overflow}, 32'd1);
    chk("ovf_drops", {24'd0, drop_count}, 32'd2);
    begin
      logic [7:0] first_stamp;
      first_stamp = sb[0][23:16];
      for (int i = 0; i < 8; i++) begin
        chk("drain_order", {16'd0, out_data}, 32'(i + 1));
        chk("drain_stamp_seq", {24'd0, out_stamp}, {24'd0, first_stamp + 8'(i)});
        step(0, 16'h0, 1, 0);
      end
    end
    step(0, 16'h0, 0, 1);

    // full with simultaneous push and pop
    for (int i = 0; i < 8; i++) step(1, 16'h0200 + 16'(i), 0, 0);
    step(1, 16'hBEEF, 1, 0);
    chk("pp_count", {28'd0, count}, 32'd8);
    chk("pp_overflow", {31'd0, overflow}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) chk("pp_beef_8th", {16'd0, out_data}, 32'hBEEF);
      step(0, 16'h0, 1, 0);
    end

    // back-pressure stability
    step(1, 16'h0301, 0, 0);
    step(1, 16'h0302, 0, 0);
    step(1, 16'h0303, 0, 0);
    step(0, 16'h0, 0, 0);
    chk("bp_hold1", {16'd0, out_data}, 32'h0301);
    step(0, 16'h0, 0, 0);
    chk("bp_hold2", {16'd0, out_data}, 32'h0301);
    step(0, 16'h0, 1, 0);
    chk("bp_advance", {16'd0, out_data}, 32'h0302);
    step(0, 16'h0, 1, 0);
    step(0, 16'h0, 1, 0);

    // wrap-around through stamp 255 -> 0
    for (int i = 0; i < 300 && stamp_m != 8'd245; i++) step(0, 16'h0, 0, 0);
    for (int i = 0; i < 20; i++) step(1, 16'h0400 + 16'(i), 1, 0);
    for (int i = 0; i < 3; i++) step(0, 16'h0, 1, 0);
    chk("wrap_empty", {31'd0, empty}, 32'd1);

    // clr mid-stream with concurrent capture
    for (int i = 1; i <= 10; i++) step(1, 16'h0500 + 16'(i), 0, 0);
    for (int i = 0; i < 3; i++) step(0, 16'h0, 1, 0);
    chk("clr_pre_count", {28'd0, count}, 32'd5);
    step(1, 16'hCAFE, 0, 1);
    chk("clr_count", {28'd0, count}, 32'd0);
    chk("clr_overflow", {31'd0, overflow}, 32'd0);
    chk("clr_drop", {24'd0, drop_count}, 32'd0);
    chk("clr_valid", {31'd0, out_valid}, 32'd0);

    // async reset between edges
    step(1, 16'h0601, 0, 0);
    step(1, 16'h0602, 0, 0);
    check_state();
    #2 rst = 1'b0;
    #1;
    chk("arst_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_count", {28'd0, count}, 32'd0);
    chk("arst_data", {16'd0, out_data}, 32'd0);
    sb.delete();
    ov_m = 1'b0;
    drop_m = '0;
    #1 rst = 1'b1;
    @(negedge clk);
    step(1, 16'h0777, 0, 0);
    step(0, 16'h0, 1, 0);
    check_state();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
